serial_rx: RTL and testbench

Byte-oriented asynchronous serial receiver: the receiving end of a start/stop-framed, LSB-first single-wire link. It oversamples the line with a baud counter, deserialises each frame into a parallel word, and presents it on a valid/ready output with a one-entry holding register. It sits between a pad-level serial input and any parallel consumer in the design, and reports framing and overrun errors.

---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_rx_if.sv | 27 ++
 rtl/serial_rx_sync2.sv | 27 ++
 rtl/serial_rx.sv | 154 +++++++++++++++
 tb/tb_serial_rx.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path.
//   rx_state_t        receiver FSM states
//   DEF_CLKS_PER_BIT  default clock cycles per bit period
//   DEF_DATA_BITS     default data bits per frame
//   LINE_IDLE         level of an idle serial line
package serial_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 16;
  localparam int DEF_DATA_BITS    = 8;

  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/serial_rx_if.sv
// Parallel output side of the serial receiver.
//   data       received word, LSB = first bit on the line
//   valid      data holds an unconsumed word
//   ready      consumer accepts data on a valid && ready cycle
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: completed word dropped
//
// Handshake: a word transfers on every cycle where valid && ready are both
// high at the rising clock edge. While valid is high, data is held stable.
// valid never waits for ready and no output depends combinationally on ready.
interface serial_rx_if import serial_pkg::*; #(
  parameter int DATA_BITS = DEF_DATA_BITS
) ();

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 ready;
  logic                 frame_err;
  logic                 overrun;

  modport master (output data, output valid, output frame_err, output overrun,
                  input ready);

  modport slave (input data, input valid, input frame_err, input overrun,
                 output ready);

endinterface

// File: rtl/serial_rx_sync2.sv
// Two-flop synchroniser for pad-level inputs asynchronous to clk.
//   clk      sampling clock
//   rst      synchronous active-high reset; both flops load RST_VAL
//   d        asynchronous input
//   q        synchronised output (two cycles of latency)
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= RST_VAL;
      q  <= RST_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Start/stop framed, LSB-first asynchronous serial receiver with a one-entry
// holding register on a valid/ready output.
//   clk        sole clock
//   rst        synchronous active-high reset
//   rxd        serial line, idle high, asynchronous to clk
//   rx         output bundle (data/valid/ready/frame_err/overrun)
//   state_dbg  current receiver FSM state
// CLKS_PER_BIT must be even and >= 4; DATA_BITS must be 5..8.
module serial_rx import serial_pkg::*; #(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEF_DATA_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  serial_rx_if.master rx,
  output rx_state_t   state_dbg
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IX = IW'(DATA_BITS - 1);

  rx_state_t            state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [IW-1:0]        idx, idx_n;
  logic [DATA_BITS-1:0] shift;
  logic                 rxs, rxs_d;
  logic                 samp_en, word_done, stop_bad;
  logic                 done_q, bad_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, ferr_q, ovr_q;

  sync2 #(.RST_VAL(LINE_IDLE)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  // FSM state register plus the datapath it steers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      rxs_d <= LINE_IDLE;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      rxs_d <= rxs;
      if (samp_en) begin
        for (int i = 0; i < DATA_BITS; i++) begin
          if (idx == IW'(i)) shift[i] <= rxs;
        end
      end
    end
  end

  // Next-state and sampling decisions.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    samp_en   = 1'b0;
    word_done = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        if (rxs_d == LINE_IDLE && rxs != LINE_IDLE) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        // Half a bit period in, re-check the line: still low means a real
        // start bit, high means a glitch and we silently go back to idle.
        if (cnt == HALF_M1) begin
          cnt_n = '0;
          if (rxs == 1'b0) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        // From mid-start, every full period lands at mid-bit.
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          samp_en = 1'b1;
          idx_n   = idx + 1'b1;
          if (idx == LAST_IX) state_n = STOP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (rxs == 1'b1) word_done = 1'b1;
          else             stop_bad  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output stage runs one cycle behind the stop sample. shift cannot change
  // in that cycle because a new frame needs far longer to reach DATA.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      done_q <= word_done;
      bad_q  <= stop_bad;
      ferr_q <= bad_q;
      ovr_q  <= 1'b0;
      if (valid_q && rx.ready) valid_q <= 1'b0;
      if (done_q) begin
        // Holding register is free if empty or being drained this cycle.
        if (!valid_q || rx.ready) begin
          data_q  <= shift;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end
    end
  end

  assign rx.data      = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.overrun   = ovr_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx with default parameters: directed scenarios followed by
// randomized frames checked against expected events derived from the frame
// timing formula.
module tb_serial_rx;
  import serial_pkg::*;

  localparam int C  = 16;
  localparam int D  = 8;
  localparam int LAT = 3 + C / 2 + (D + 1) * C;  // 155 cycles from T0
  localparam int EW = 41;                         // {is_ferr, data[7:0], cycle[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  serial_rx_if #(.DATA_BITS(D)) rx_bus ();
  rx_state_t st_dbg;

  serial_rx #(.CLKS_PER_BIT(C), .DATA_BITS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx        (rx_bus),
    .state_dbg (st_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [EW-1:0] exp_q[$];
  bit   mon_on = 1'b0;

  int vhigh_cnt = 0, ferr_cnt = 0, ovr_cnt = 0, acc_cnt = 0;
  int rise_cyc = 0, ferr_cyc = 0, ovr_cyc = 0;
  logic [D-1:0] acc_data = '0;
  logic valid_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_bus.valid) vhigh_cnt++;
      if (rx_bus.valid && !valid_prev) rise_cyc = cyc;
      if (rx_bus.frame_err) begin ferr_cnt++; ferr_cyc = cyc; end
      if (rx_bus.overrun) begin ovr_cnt++; ovr_cyc = cyc; end
      if (rx_bus.valid && rx_bus.ready) begin
        acc_cnt++;
        acc_data = rx_bus.data;
      end
      if (mon_on) begin
        if (rx_bus.overrun) check("rnd_overrun", 32'(rx_bus.overrun), 32'd0);
        if ((rx_bus.valid && rx_bus.ready) || rx_bus.frame_err) begin
          if (exp_q.size() == 0) begin
            check("rnd_unexpected_event", 32'd1, 32'd0);
          end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("rnd_kind", 32'(rx_bus.frame_err), 32'(e[40]));
            if (!e[40]) check("rnd_data", 32'(rx_bus.data), 32'(e[39:32]));
            check("rnd_cycle", 32'(cyc), e[31:0]);
          end
        end
      end
    end
    valid_prev = rx_bus.valid;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold_bit(input logic b);
    rxd = b;
    tick(C);
  endtask

  // Called at posedge+1; the next posedge is T0 (first capture of the start bit).
  task automatic send_frame(input logic [D-1:0] d, input logic stop_bit, output int t0);
    t0 = cyc + 1;
    hold_bit(1'b0);
    for (int i = 0; i < D; i++) hold_bit(d[i]);
    hold_bit(stop_bit);
    rxd = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int t0, t0a, t0b, tw;
  int v0, f0, o0, a0;
  int gap;
  logic [D-1:0] rd;
  logic bad, prev_bad;

  task automatic snap();
    v0 = vhigh_cnt; f0 = ferr_cnt; o0 = ovr_cnt; a0 = acc_cnt;
  endtask

  initial begin
    rx_bus.ready = 1'b1;
    rst = 1'b1;
    rxd = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_data", 32'(rx_bus.data), 32'd0);
    check("rst_valid", 32'(rx_bus.valid), 32'd0);
    check("rst_frame_err", 32'(rx_bus.frame_err), 32'd0);
    check("rst_overrun", 32'(rx_bus.overrun), 32'd0);
    check("rst_state", 32'(st_dbg), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    tick(5);

    // 1: single frame, ready high
    snap();
    send_frame(8'hA5, 1'b1, t0);
    tick(5);
    check("t1_data", 32'(acc_data), 32'h A5);
    check("t1_valid_cycle", 32'(rise_cyc), 32'(t0 + LAT));
    check("t1_valid_len", 32'(vhigh_cnt - v0), 32'd1);
    check("t1_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t1_ovr", 32'(ovr_cnt - o0), 32'd0);

    // 2: start-bit glitch
    snap();
    rxd = 1'b0;
    tick(4);
    check("t2_in_start", 32'(st_dbg), 32'(START));
    rxd = 1'b1;
    tick(40);
    check("t2_idle", 32'(st_dbg), 32'(IDLE));
    check("t2_valid", 32'(vhigh_cnt - v0), 32'd0);
    check("t2_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 3: framing error
    snap();
    send_frame(8'h3C, 1'b0, t0);
    tick(5);
    check("t3_ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
    check("t3_ferr_cycle", 32'(ferr_cyc), 32'(t0 + LAT));
    check("t3_valid", 32'(vhigh_cnt - v0), 32'd0);
    check("t3_data_kept", 32'(rx_bus.data), 32'h A5);

    // 4: overrun with ready low, then drain one word
    rx_bus.ready = 1'b0;
    tick(4);
    snap();
    send_frame(8'h11, 1'b1, t0a);
    send_frame(8'h22, 1'b1, t0b);
    tick(5);
    check("t4_valid", 32'(rx_bus.valid), 32'd1);
    check("t4_data", 32'(rx_bus.data), 32'h11);
    check("t4_ovr_cnt", 32'(ovr_cnt - o0), 32'd1);
    check("t4_ovr_cycle", 32'(ovr_cyc), 32'(t0b + LAT));
    rx_bus.ready = 1'b1;
    tick(1);
    rx_bus.ready = 1'b0;
    check("t4_valid_cleared", 32'(rx_bus.valid), 32'd0);
    check("t4_acc_data", 32'(acc_data), 32'h11);
    check("t4_acc_cnt", 32'(acc_cnt - a0), 32'd1);

    // 5: ready on exactly the second completion cycle
    tick(4);
    snap();
    t0a = cyc + 1;
    t0b = t0a + (D + 2) * C;
    fork
      begin
        send_frame(8'h44, 1'b1, t0);
        send_frame(8'h22, 1'b1, t0);
      end
      begin
        for (int i = 0; i < 600 && cyc != t0b + LAT - 1; i++) tick(1);
        check("t5_ready_timing", 32'(cyc), 32'(t0b + LAT - 1));
        rx_bus.ready = 1'b1;
        tick(1);
        rx_bus.ready = 1'b0;
      end
    join
    tick(5);
    check("t5_data", 32'(rx_bus.data), 32'h22);
    check("t5_valid", 32'(rx_bus.valid), 32'd1);
    check("t5_ovr", 32'(ovr_cnt - o0), 32'd0);
    check("t5_first_consumed", 32'(acc_data), 32'h44);
    check("t5_acc_cnt", 32'(acc_cnt - a0), 32'd1);
    rx_bus.ready = 1'b1;
    tick(2);
    check("t5_drain_data", 32'(acc_data), 32'h22);
    check("t5_drain_valid", 32'(rx_bus.valid), 32'd0);

    // 6: reset in the middle of data bit 3, then a clean frame
    tick(4);
    snap();
    rd = 8'hC3;
    hold_bit(1'b0);
    for (int i = 0; i < 3; i++) hold_bit(rd[i]);
    rxd = rd[3];
    tick(C / 2);
    rst = 1'b1;
    rxd = 1'b1;
    tick(2);
    rst = 1'b0;
    check("t6_state_after_rst", 32'(st_dbg), 32'(IDLE));
    tick(30);
    check("t6_no_valid", 32'(vhigh_cnt - v0), 32'd0);
    check("t6_no_ferr", 32'(ferr_cnt - f0), 32'd0);
    check("t6_no_ovr", 32'(ovr_cnt - o0), 32'd0);
    send_frame(8'h7E, 1'b1, t0);
    tick(5);
    check("t6_data", 32'(acc_data), 32'h7E);
    check("t6_valid_cycle", 32'(rise_cyc), 32'(t0 + LAT));

    // 7: randomized frames with random gaps and occasional bad stop bits
    mon_on = 1'b1;
    prev_bad = 1'b0;
    for (int n = 0; n < 24; n++) begin
      rd  = D'($urandom_range(0, (1 << D) - 1));
      bad = ($urandom_range(0, 4) == 0);
      gap = $urandom_range(prev_bad ? 2 : 0, 12);
      tick(gap);
      tw = cyc + 1 + LAT;
      exp_q.push_back({bad, bad ? 8'h00 : rd, 32'(tw)});
      send_frame(rd, !bad, t0);
      prev_bad = bad;
    end
    tick(10);
    check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);
    mon_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
